// File: rtl/cpu_sram_like_bridge.sv
// cpu_sram_like_bridge: converts a CPU's stall-style memory port into a
// variable-latency sram-like bus master. At most one live access is in
// progress at a time. Accesses abandoned by a flush are left in flight and
// their responses are dropped when they return.
module cpu_sram_like_bridge #(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int MAX_OUT = 2,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  // CPU side
  input  logic              cpu_req_i,
  input  logic              cpu_wr_i,
  input  logic [1:0]        cpu_size_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic [STRB_W-1:0] cpu_wstrb_i,
  input  logic              cpu_flush_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  // bus side
  output logic              req_o,
  output logic              wr_o,
  output logic [1:0]        size_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  input  logic              addr_ok_i,
  input  logic              data_ok_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              proto_err_o
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e              state_q;
  logic                req_q, wr_q, kill_q, proto_err_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, cpu_rdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]    disc_cnt_q, disc_cnt_d;

  logic acc, rsp, drop, live, can_issue, disc_inc;

  // Bus events this cycle. A response with nothing outstanding is a protocol
  // error and is otherwise ignored; a response with discards pending is
  // always the oldest flushed transaction, since the bus answers in order.
  assign acc       = req_q & addr_ok_i;
  assign rsp       = data_ok_i & (out_cnt_q != '0);
  assign drop      = rsp & (disc_cnt_q != '0);
  assign live      = rsp & ~drop & (state_q == WAIT);
  assign can_issue = cpu_req_i & ~cpu_flush_i & (out_cnt_q < CNT_W'(MAX_OUT));

  // Which flushes turn an accepted transaction into one to discard.
  always_comb begin
    disc_inc = 1'b0;
    case (state_q)
      REQ:     disc_inc = acc & (kill_q | cpu_flush_i);
      // A stale drop in the same cycle does not answer the live access,
      // so a flush still has to mark it for discard.
      WAIT:    disc_inc = cpu_flush_i & ~live;
      default: disc_inc = 1'b0;
    endcase
  end

  assign out_cnt_d  = out_cnt_q + CNT_W'(acc) - CNT_W'(rsp);
  assign disc_cnt_d = disc_cnt_q + CNT_W'(disc_inc) - CNT_W'(drop);

  // Outstanding/discard counters and the sticky protocol error flag.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      out_cnt_q   <= '0;
      disc_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      if (data_ok_i && out_cnt_q == '0)
        proto_err_q <= 1'b1;
    end
  end

  // Access FSM; bus fields are captured on issue and stay put until the next.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      kill_q      <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (can_issue) begin
            req_q   <= 1'b1;
            wr_q    <= cpu_wr_i;
            size_q  <= cpu_size_i;
            addr_q  <= cpu_addr_i;
            wdata_q <= cpu_wdata_i;
            wstrb_q <= cpu_wstrb_i;
            kill_q  <= 1'b0;
            state_q <= REQ;
          end
        end
        REQ: begin
          // req may not be withdrawn, so a flush here only arms kill.
          if (addr_ok_i) begin
            req_q   <= 1'b0;
            kill_q  <= 1'b0;
            state_q <= (kill_q || cpu_flush_i) ? IDLE : WAIT;
          end else if (cpu_flush_i) begin
            kill_q <= 1'b1;
          end
        end
        WAIT: begin
          if (live) begin
            if (cpu_flush_i) begin
              state_q <= IDLE;
            end else begin
              if (!wr_q) cpu_rdata_q <= rdata_i;
              state_q <= RESP;
            end
          end else if (cpu_flush_i) begin
            state_q <= IDLE;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_stall_o = cpu_req_i & (state_q != RESP);
  assign cpu_rdata_o = cpu_rdata_q;
  assign req_o       = req_q;
  assign wr_o        = wr_q;
  assign size_o      = size_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign proto_err_o = proto_err_q;

endmodule
